mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM register. Takes the ALU result, store data and control bits produced by EX/MEM, performs loads and stores against data memory over a request/acknowledge handshake, and stalls the upstream pipeline while an access is outstanding. Registers its results into an internal MEM/WB register that feeds write-back.

## Interface
- DATA_WIDTH, 32, data and address width
- REG_ADDR_WIDTH, 5, register-file index width
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without memAck; used only with timeout compiled in

- clock  in  1  pipeline clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- inResult  in  DATA_WIDTH  ALU result / memory address, from EX/MEM
- inReadRegister2  in  DATA_WIDTH  store data, from EX/MEM
- inMemRead, inMemWrite, inMemToReg, inRegWrite  in  1 each  control bits, from EX/MEM
- inWriteRegister  in  REG_ADDR_WIDTH  destination register, from EX/MEM
- memReq  out  1  access request, registered
- memWe  out  1  1 = store, 0 = load; valid while memReq
- memAddr, memWdata  out  DATA_WIDTH  address / store data; valid while memReq
- memRdata  in  DATA_WIDTH  load data; valid in the cycle memAck is high
- memAck  in  1  access complete, single-cycle pulse
- stall  out  1  combinational; upstream stages and EX/MEM hold while high
- outReadData, outResult  out  DATA_WIDTH  MEM/WB load data / ALU result
- outMemToReg, outRegWrite  out  1 each  MEM/WB control
- outWriteRegister  out  REG_ADDR_WIDTH  MEM/WB destination
- memError  out  1  sticky timeout flag

## Operation
- States: IDLE, ACCESS.
- IDLE, no memory op (inMemRead = inMemWrite = 0): MEM/WB captures inResult, inMemToReg, inRegWrite, inWriteRegister. outReadData holds its previous value. stall = 0.
- IDLE, memory op: stall = 1. At the edge, latch memAddr = inResult, memWdata = inReadRegister2, memWe = inMemWrite, and set memReq = 1. Go to ACCESS. MEM/WB takes a bubble (outRegWrite = 0, outMemToReg = 0).
- inMemRead and inMemWrite both high: treated as a store.
- ACCESS, memAck = 0: stall = 1. memReq, memAddr, memWdata and memWe are held stable. MEM/WB takes a bubble.
- ACCESS, memAck = 1: stall = 0. At the edge, MEM/WB captures outReadData = memRdata (loads only; stores leave it unchanged) plus the in* control and destination bits. memReq drops and the state returns to IDLE. Upstream advances on the same edge, so the next instruction is seen in IDLE.
- memAck while in IDLE: ignored.
- stall = (IDLE & (inMemRead | inMemWrite)) | (ACCESS & ~memAck), plus the timeout term below.

## Timing
- Reset (asynchronous): state = IDLE; memReq, memWe, memAddr, memWdata, every out* bit and memError = 0; timeout counter = 0. Reset during ACCESS drops memReq immediately, and the access is abandoned.
- Non-memory instruction: 1-cycle latency from EX/MEM to MEM/WB, no stall.
- Memory instruction with memAck in the k-th ACCESS cycle (k ≥ 1):
  - stall high for k cycles;
  - MEM/WB valid k+1 edges after the instruction reaches mem_stage.
- memReq is high for exactly k cycles per access. Back-to-back memory ops produce exactly one cycle of memReq = 0 between accesses (the IDLE cycle).

## Configuration
- MEM_STAGE_TIMEOUT_EN defined: an 8..16-bit counter (sized from TIMEOUT_CYCLES) increments each ACCESS cycle without memAck.
  - When it reaches TIMEOUT_CYCLES in ACCESS without memAck: stall = 0 that cycle; at the edge, memReq drops, the state returns to IDLE, MEM/WB takes a bubble, and memError sets (sticky until reset).
  - memAck arriving on the terminal cycle wins: normal completion, no error.
- Not defined: ACCESS waits indefinitely; no counter; memError tied 0; TIMEOUT_CYCLES unused.

## Structure
- Package mem_stage_pkg: state enum (IDLE, ACCESS), DATA_WIDTH/REG_ADDR_WIDTH defaults, bubble constant for MEM/WB control.
- Sub-module mem_wb: the MEM/WB register, same port style as the EX/MEM register, plus reset and a bubble input. mem_stage holds only the FSM, the request latch and the counter.

## Test plan
- Reset, then an ALU op (inResult = 0x0000_0010, inRegWrite = 1, inWriteRegister = 3) → next edge outResult = 0x10, outRegWrite = 1, outWriteRegister = 3; stall never high.
- Load from 0x100, memAck on the 3rd ACCESS cycle with memRdata = 0xDEAD_BEEF → stall high 3 cycles, memReq high 3 cycles, then outReadData = 0xDEADBEEF, outMemToReg = 1.
- Store 0x1234_5678 to 0x200, memAck on the 1st cycle → memWe = 1, memAddr = 0x200, memWdata = 0x12345678; stall 1 cycle; outReadData unchanged.
- Two back-to-back loads → exactly one cycle of memReq = 0 between them; both results appear in order.
- Reset asserted mid-ACCESS → memReq and all outputs 0 immediately, state IDLE; a subsequent load proceeds normally.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no memAck → memReq drops after 4 cycles, memError = 1 and stays set, outRegWrite = 0; memAck on cycle 4 instead → normal completion, memError = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory-access stage
// Contents: FSM state enum, default widths, MEM/WB control bubble, timeout counter sizing.
package mem_stage_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_t;

  // Write-back control bits carried by MEM/WB.
  typedef struct packed {
    logic memToReg;
    logic regWrite;
  } wbCtrl_t;

  // A bubble must never write the register file.
  localparam wbCtrl_t WB_BUBBLE = '{memToReg: 1'b0, regWrite: 1'b0};

  // Timeout counter width: enough to hold TIMEOUT_CYCLES, clamped to 8..16 bits.
  function automatic int timeoutWidth(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_mem_wb.sv
// rtl/mem_stage_mem_wb.sv - MEM/WB pipeline register feeding write-back
// Ports:
//   clock, reset          - pipeline clock, asynchronous active-high reset
//   bubble                - insert a bubble (control bits cleared, data held)
//   readDataEn            - capture inReadData (completed loads only)
//   inReadData, inResult  - load data / ALU result
//   inMemToReg, inRegWrite, inWriteRegister - write-back control and destination
//   out*                  - registered copies of the above
module mem_wb
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      bubble,
  input  logic                      readDataEn,
  input  logic [DATA_WIDTH-1:0]     inReadData,
  input  logic [DATA_WIDTH-1:0]     inResult,
  input  logic                      inMemToReg,
  input  logic                      inRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] inWriteRegister,
  output logic [DATA_WIDTH-1:0]     outReadData,
  output logic [DATA_WIDTH-1:0]     outResult,
  output logic                      outMemToReg,
  output logic                      outRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] outWriteRegister
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outReadData      <= '0;
      outResult        <= '0;
      outMemToReg      <= 1'b0;
      outRegWrite      <= 1'b0;
      outWriteRegister <= '0;
    end else if (bubble) begin
      // Only the control bits matter for a bubble; data fields keep their values.
      {outMemToReg, outRegWrite} <= WB_BUBBLE;
    end else begin
      outResult        <= inResult;
      outMemToReg      <= inMemToReg;
      outRegWrite      <= inRegWrite;
      outWriteRegister <= inWriteRegister;
      if (readDataEn) begin
        outReadData <= inReadData;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with request/acknowledge data memory port
// Optional feature macro: MEM_STAGE_TIMEOUT_EN (abandon an access after TIMEOUT_CYCLES, set memError).
// Ports:
//   clock, reset                      - pipeline clock, asynchronous active-high reset
//   inResult, inReadRegister2         - address / store data from EX/MEM
//   inMemRead, inMemWrite, inMemToReg, inRegWrite, inWriteRegister - EX/MEM control
//   memReq, memWe, memAddr, memWdata  - registered data-memory request
//   memRdata, memAck                  - data-memory response
//   stall                             - hold upstream stages (combinational)
//   out*                              - MEM/WB register outputs
//   memError                          - sticky access-timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     inResult,
  input  logic [DATA_WIDTH-1:0]     inReadRegister2,
  input  logic                      inMemRead,
  input  logic                      inMemWrite,
  input  logic                      inMemToReg,
  input  logic                      inRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] inWriteRegister,
  output logic                      memReq,
  output logic                      memWe,
  output logic [DATA_WIDTH-1:0]     memAddr,
  output logic [DATA_WIDTH-1:0]     memWdata,
  input  logic [DATA_WIDTH-1:0]     memRdata,
  input  logic                      memAck,
  output logic                      stall,
  output logic [DATA_WIDTH-1:0]     outReadData,
  output logic [DATA_WIDTH-1:0]     outResult,
  output logic                      outMemToReg,
  output logic                      outRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] outWriteRegister,
  output logic                      memError
);

  memState_t state, nextState;
  logic      memOp;
  logic      wbBubble;
  logic      wbReadEn;
  logic      timeoutHit;

  // A combined read+write request is handled as a store (memWe follows inMemWrite).
  assign memOp = inMemRead | inMemWrite;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int COUNT_WIDTH = timeoutWidth(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] timeoutCount;

  // The counter holds the number of ACCESS cycles already spent waiting, so the
  // TIMEOUT_CYCLES-th waiting cycle is the terminal one. memAck on that cycle wins.
  assign timeoutHit = (state == ACCESS) && !memAck &&
                      (timeoutCount == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeoutCount <= '0;
      memError     <= 1'b0;
    end else begin
      if ((state == ACCESS) && !memAck && !timeoutHit) begin
        timeoutCount <= timeoutCount + 1'b1;
      end else begin
        timeoutCount <= '0;
      end
      if (timeoutHit) begin
        memError <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign memError   = 1'b0;
`endif

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    wbBubble  = 1'b1;
    wbReadEn  = 1'b0;
    case (state)
      IDLE: begin
        if (memOp) begin
          stall     = 1'b1;
          nextState = ACCESS;
        end else begin
          wbBubble = 1'b0;
        end
      end
      ACCESS: begin
        if (memAck) begin
          // EX/MEM was held during the access, so in* still describe this instruction.
          wbBubble  = 1'b0;
          wbReadEn  = ~memWe;
          nextState = IDLE;
        end else if (timeoutHit) begin
          nextState = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && memOp) begin
        memReq   <= 1'b1;
        memWe    <= inMemWrite;
        memAddr  <= inResult;
        memWdata <= inReadRegister2;
      end else if ((state == ACCESS) && (nextState == IDLE)) begin
        memReq <= 1'b0;
      end
    end
  end

  mem_wb #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) memWbReg (
    .clock           (clock),
    .reset           (reset),
    .bubble          (wbBubble),
    .readDataEn      (wbReadEn),
    .inReadData      (memRdata),
    .inResult        (inResult),
    .inMemToReg      (inMemToReg),
    .inRegWrite      (inRegWrite),
    .inWriteRegister (inWriteRegister),
    .outReadData     (outReadData),
    .outResult       (outResult),
    .outMemToReg     (outMemToReg),
    .outRegWrite     (outRegWrite),
    .outWriteRegister(outWriteRegister)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

  logic        clock;
  logic        reset;
  logic [31:0] inResult;
  logic [31:0] inReadRegister2;
  logic        inMemRead;
  logic        inMemWrite;
  logic        inMemToReg;
  logic        inRegWrite;
  logic [4:0]  inWriteRegister;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;
  logic        stall;
  logic [31:0] outReadData;
  logic [31:0] outResult;
  logic        outMemToReg;
  logic        outRegWrite;
  logic [4:0]  outWriteRegister;
  logic        memError;

  mem_stage #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .inResult        (inResult),
    .inReadRegister2 (inReadRegister2),
    .inMemRead       (inMemRead),
    .inMemWrite      (inMemWrite),
    .inMemToReg      (inMemToReg),
    .inRegWrite      (inRegWrite),
    .inWriteRegister (inWriteRegister),
    .memReq          (memReq),
    .memWe           (memWe),
    .memAddr         (memAddr),
    .memWdata        (memWdata),
    .memRdata        (memRdata),
    .memAck          (memAck),
    .stall           (stall),
    .outReadData     (outReadData),
    .outResult       (outResult),
    .outMemToReg     (outMemToReg),
    .outRegWrite     (outRegWrite),
    .outWriteRegister(outWriteRegister),
    .memError        (memError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] result;
    logic [31:0] readData;
    logic        memToReg;
    logic        regWrite;
    logic [4:0]  writeRegister;
  } wbExp_t;

  wbExp_t      sbQ[$];
  logic [31:0] modelReadData;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic driveNop();
    inResult        = 32'h0;
    inReadRegister2 = 32'h0;
    inMemRead       = 1'b0;
    inMemWrite      = 1'b0;
    inMemToReg      = 1'b0;
    inRegWrite      = 1'b0;
    inWriteRegister = 5'd0;
  endtask

  // Present one instruction at a negedge; for memory ops, acknowledge in the k-th
  // ACCESS cycle. Returns at the negedge after MEM/WB has captured the result.
  task automatic issue(input logic isRead, input logic isWrite, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic m2r, input logic rw,
                       input logic [4:0] dst, input int k, input logic [31:0] rdata);
    wbExp_t e;
    wbExp_t got;
    int     stallCycles;
    int     reqCycles;
    inResult        = addr;
    inReadRegister2 = wdata;
    inMemRead       = isRead;
    inMemWrite      = isWrite;
    inMemToReg      = m2r;
    inRegWrite      = rw;
    inWriteRegister = dst;
    if (isRead && !isWrite) modelReadData = rdata;
    e = '{result: addr, readData: modelReadData, memToReg: m2r, regWrite: rw, writeRegister: dst};
    sbQ.push_back(e);
    #1;
    stallCycles = 0;
    reqCycles   = 0;
    if (isRead || isWrite) begin
      if (stall === 1'b1) stallCycles++;
      @(posedge clock);
      @(negedge clock);
      for (int c = 1; c <= k; c++) begin
        if (memReq === 1'b1) reqCycles++;
        check("memAddr", memAddr, addr);
        check("memWe", memWe, isWrite);
        if (isWrite) check("memWdata", memWdata, wdata);
        check("bubble_regWrite", outRegWrite, 1'b0);
        if (c == k) begin
          memAck   = 1'b1;
          memRdata = rdata;
        end else begin
          memRdata = 32'hBAD0_0000 | c;
        end
        #1;
        if (stall === 1'b1) stallCycles++;
        @(posedge clock);
        @(negedge clock);
        memAck   = 1'b0;
        memRdata = 32'h0;
      end
      check("stall_cycles", stallCycles, k);
      check("memReq_cycles", reqCycles, k);
      check("memReq_after", memReq, 1'b0);
    end else begin
      check("stall_nonmem", stall, 1'b0);
      @(posedge clock);
      @(negedge clock);
    end
    got = sbQ.pop_front();
    check("outResult", outResult, got.result);
    check("outReadData", outReadData, got.readData);
    check("outMemToReg", outMemToReg, got.memToReg);
    check("outRegWrite", outRegWrite, got.regWrite);
    check("outWriteRegister", outWriteRegister, got.writeRegister);
    driveNop();
  endtask

  task automatic checkAllClear(input string tag);
    check({tag, "_memReq"}, memReq, 1'b0);
    check({tag, "_memWe"}, memWe, 1'b0);
    check({tag, "_memAddr"}, memAddr, 32'h0);
    check({tag, "_outReadData"}, outReadData, 32'h0);
    check({tag, "_outResult"}, outResult, 32'h0);
    check({tag, "_outRegWrite"}, outRegWrite, 1'b0);
    check({tag, "_outMemToReg"}, outMemToReg, 1'b0);
    check({tag, "_outWriteRegister"}, outWriteRegister, 5'd0);
    check({tag, "_memError"}, memError, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    memAck        = 1'b0;
    memRdata      = 32'h0;
    modelReadData = 32'h0;
    driveNop();
    @(negedge clock);
    @(negedge clock);
    checkAllClear("reset");
    check("reset_stall", stall, 1'b0);
    reset = 1'b0;

    // ALU op, no memory access
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 5'd3, 0, 32'h0);
    // Load from 0x100, ack on 3rd ACCESS cycle
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 5'd5, 3, 32'hDEAD_BEEF);
    // Store 0x12345678 to 0x200, ack on 1st cycle; outReadData must stay 0xDEADBEEF
    issue(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 1, 32'hFFFF_FFFF);
    // Read+write together behaves as a store
    issue(1'b1, 1'b1, 32'h0000_0204, 32'hA5A5_5A5A, 1'b0, 1'b0, 5'd0, 2, 32'h0BAD_F00D);
    // Back-to-back loads: the memReq_after check of the first is the single gap cycle
    issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 1'b1, 5'd7, 2, 32'h1111_2222);
    issue(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1'b1, 1'b1, 5'd8, 1, 32'h3333_4444);
    // memAck while idle is ignored
    memAck   = 1'b1;
    memRdata = 32'h7777_7777;
    issue(1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 1'b1, 5'd9, 0, 32'h0);
    memAck   = 1'b0;
    check("idle_ack_memReq", memReq, 1'b0);

    // Reset in the middle of an access
    inResult   = 32'h0000_0400;
    inMemRead  = 1'b1;
    inMemToReg = 1'b1;
    inRegWrite = 1'b1;
    inWriteRegister = 5'd4;
    @(posedge clock);
    @(negedge clock);
    check("midaccess_memReq", memReq, 1'b1);
    reset = 1'b1;
    #1;
    driveNop();
    #1;
    checkAllClear("midreset");
    check("midreset_stall", stall, 1'b0);
    @(negedge clock);
    reset         = 1'b0;
    modelReadData = 32'h0;
    issue(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b1, 1'b1, 5'd10, 2, 32'hCAFE_0001);

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack: abandoned after 4 ACCESS cycles
    inResult   = 32'h0000_0600;
    inMemRead  = 1'b1;
    inMemToReg = 1'b1;
    inRegWrite = 1'b1;
    inWriteRegister = 5'd11;
    @(posedge clock);
    @(negedge clock);
    for (int c = 1; c <= 4; c++) begin
      check("to_memReq", memReq, 1'b1);
      check("to_stall", stall, (c == 4) ? 1'b0 : 1'b1);
      @(posedge clock);
      @(negedge clock);
    end
    driveNop();
    check("to_memReq_drop", memReq, 1'b0);
    check("to_memError", memError, 1'b1);
    check("to_outRegWrite", outRegWrite, 1'b0);
    @(negedge clock);
    check("to_memError_sticky", memError, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset         = 1'b0;
    modelReadData = 32'h0;
    // Ack on the terminal cycle completes normally
    issue(1'b1, 1'b0, 32'h0000_0700, 32'h0, 1'b1, 1'b1, 5'd12, 4, 32'h5555_AAAA);
    check("to_ack_memError", memError, 1'b0);
`else
    // Long wait without timeout support still completes
    issue(1'b1, 1'b0, 32'h0000_0700, 32'h0, 1'b1, 1'b1, 5'd12, 6, 32'h5555_AAAA);
    check("no_timeout_memError", memError, 1'b0);
`endif

    check("scoreboard_empty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
